// File: rtl/ddrphy_pwrseq_pkg.sv
// Shared types and default timing for the LPDDR5 PHY power/reset sequencer.
package ddrphy_pwrseq_pkg;

    localparam int unsigned CntWDef   = 16;
    localparam int unsigned TSupDef   = 8;
    localparam int unsigned TPwrokDef = 64;
    localparam int unsigned TRstDef   = 128;
    localparam int unsigned TApbDef   = 16;

    typedef enum logic [3:0] {
        StOff   = 4'd0,
        StVaa   = 4'd1,
        StVdd   = 4'd2,
        StVddq  = 4'd3,
        StPwrok = 4'd4,
        StRel   = 4'd5,
        StRun   = 4'd6,
        StWApb  = 4'd7,
        StWRst  = 4'd8,
        StREnt  = 4'd9,
        StRet   = 4'd10,
        StPdn   = 4'd11
    } state_e;

    typedef struct packed {
        logic vaa_en;
        logic vdd_en;
        logic vddq_en;
        logic pwrok;
        logic presetn;
        logic dfi_reset_n;
        logic phy_reset;
        logic retention;
        logic clk_en;
        logic busy;
        logic done;
    } pwr_out_t;

    localparam pwr_out_t PwrOutRst = '{
        vaa_en:      1'b0,
        vdd_en:      1'b0,
        vddq_en:     1'b0,
        pwrok:       1'b0,
        presetn:     1'b1,
        dfi_reset_n: 1'b0,
        phy_reset:   1'b1,
        retention:   1'b0,
        clk_en:      1'b0,
        busy:        1'b0,
        done:        1'b0
    };

    // Stable states are the only ones that accept requests.
    function automatic logic is_stable(state_e s);
        return (s == StOff) || (s == StRun) || (s == StRet);
    endfunction

endpackage

// File: rtl/ddrphy_seq_timer.sv
// Loadable down-counter shared by all sequencer states; saturates at zero.
module ddrphy_seq_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddrphy_pwr_rst_seq.sv
// Power/reset sequencer for the LPDDR5 PHY: cold up, warm reset, retention and power-down,
// with all outputs registered from the next state.
module ddrphy_pwr_rst_seq
    import ddrphy_pwrseq_pkg::*;
#(
    parameter int unsigned CNT_W   = CntWDef,
    parameter int unsigned T_SUP   = TSupDef,
    parameter int unsigned T_PWROK = TPwrokDef,
    parameter int unsigned T_RST   = TRstDef,
    parameter int unsigned T_APB   = TApbDef
) (
    input  logic       apb_clk,
    input  logic       reset,
    input  logic       pwr_up_req,
    input  logic       warm_rst_req,
    input  logic       ret_enter_req,
    input  logic       ret_exit_req,
    input  logic       pwr_dn_req,
    output logic       vaa_en,
    output logic       vdd_en,
    output logic       vddq_en,
    output logic       pwrok_out,
    output logic       presetn_out,
    output logic       dfi_reset_n_out,
    output logic       phy_reset_out,
    output logic       retention_out,
    output logic       clk_en,
    output logic       busy,
    output logic       done,
    output logic [3:0] state_o
);

    localparam logic [63:0] TMax = (64'd1 << CNT_W) - 64'd1;

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("CNT_W must be in [1, 32]");
    end
    if (T_SUP < 1 || 64'(T_SUP) > TMax) begin : g_bad_t_sup
        $error("T_SUP out of range for CNT_W");
    end
    if (T_PWROK < 1 || 64'(T_PWROK) > TMax) begin : g_bad_t_pwrok
        $error("T_PWROK out of range for CNT_W");
    end
    if (T_RST < 1 || 64'(T_RST) > TMax) begin : g_bad_t_rst
        $error("T_RST out of range for CNT_W");
    end
    if (T_APB < 1 || 64'(T_APB) > TMax) begin : g_bad_t_apb
        $error("T_APB out of range for CNT_W");
    end

    state_e   state_q, state_d;
    pwr_out_t out_q, out_d;
    logic     ret_path_q, ret_path_d;
    logic     tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    // Timer is reloaded with duration-1 so each timed state lasts exactly its duration.
    function automatic logic [CNT_W-1:0] dur_m1(state_e s);
        case (s)
            StVaa, StVdd, StREnt:  dur_m1 = CNT_W'(T_SUP - 1);
            StVddq:                dur_m1 = CNT_W'(T_PWROK - 1);
            StPwrok, StWRst, StPdn: dur_m1 = CNT_W'(T_RST - 1);
            StRel, StWApb:         dur_m1 = CNT_W'(T_APB - 1);
            default:               dur_m1 = '0;
        endcase
    endfunction

    assign tmr_load = (state_d != state_q);
    assign tmr_val  = dur_m1(state_d);

    ddrphy_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (apb_clk),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StOff:   if (pwr_up_req) state_d = StVaa;
            StVaa:   if (tmr_zero) state_d = StVdd;
            StVdd:   if (tmr_zero) state_d = StVddq;
            StVddq:  if (tmr_zero) state_d = StPwrok;
            StPwrok: if (tmr_zero) state_d = StRel;
            StRel:   if (tmr_zero) state_d = StRun;
            StRun: begin
                if (pwr_dn_req) begin
                    state_d = StPdn;
                end else if (ret_enter_req) begin
                    state_d = StREnt;
                end else if (warm_rst_req) begin
                    state_d = StWApb;
                end
            end
            StWApb:  if (tmr_zero) state_d = StWRst;
            StWRst:  if (tmr_zero) state_d = StRel;
            StREnt:  if (tmr_zero) state_d = StRet;
            StRet: begin
                if (pwr_dn_req) begin
                    state_d = StPdn;
                end else if (ret_exit_req) begin
                    state_d = StVdd;
                end
            end
            StPdn:   if (tmr_zero) state_d = StOff;
            default: state_d = StOff;
        endcase
    end

    always_comb begin
        ret_path_d = ret_path_q;
        if (state_q == StRet && state_d == StVdd) begin
            ret_path_d = 1'b1;
        end else if (state_d == StRun || state_d == StOff) begin
            ret_path_d = 1'b0;
        end

        out_d             = PwrOutRst;
        out_d.vaa_en      = (state_d != StOff);
        out_d.vdd_en      = state_d inside {StVdd, StVddq, StPwrok, StRel, StRun, StWApb, StWRst,
                                            StREnt};
        out_d.vddq_en     = state_d inside {StVddq, StPwrok, StRel, StRun, StWApb, StWRst, StREnt};
        out_d.pwrok       = state_d inside {StPwrok, StRel, StRun, StWApb, StWRst, StREnt};
        out_d.clk_en      = state_d inside {StVddq, StPwrok, StRel, StRun, StWApb, StWRst, StPdn};
        out_d.presetn     = !(state_d inside {StVddq, StPwrok, StRel, StWApb, StWRst});
        out_d.dfi_reset_n = state_d inside {StRel, StRun, StWApb, StWRst, StREnt};
        out_d.phy_reset   = !(state_d inside {StRel, StRun, StWApb, StREnt});
        // On retention exit the pads stay latched until the PHY is fully back in RUN.
        out_d.retention   = (state_d inside {StREnt, StRet}) ||
                            (ret_path_d && (state_d inside {StVdd, StVddq, StPwrok, StRel}));
        if (state_d == StPdn) begin
            out_d.vaa_en  = out_q.vaa_en;
            out_d.vdd_en  = out_q.vdd_en;
            out_d.vddq_en = out_q.vddq_en;
        end
        out_d.busy = !is_stable(state_d);
        out_d.done = is_stable(state_d) && (state_d != state_q);
    end

    always_ff @(posedge apb_clk) begin
        if (reset) begin
            state_q    <= StOff;
            out_q      <= PwrOutRst;
            ret_path_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            ret_path_q <= ret_path_d;
        end
    end

    assign vaa_en          = out_q.vaa_en;
    assign vdd_en          = out_q.vdd_en;
    assign vddq_en         = out_q.vddq_en;
    assign pwrok_out       = out_q.pwrok;
    assign presetn_out     = out_q.presetn;
    assign dfi_reset_n_out = out_q.dfi_reset_n;
    assign phy_reset_out   = out_q.phy_reset;
    assign retention_out   = out_q.retention;
    assign clk_en          = out_q.clk_en;
    assign busy            = out_q.busy;
    assign done            = out_q.done;
    assign state_o         = state_q;

endmodule

// File: tb/tb_ddrphy_pwr_rst_seq.sv
// Directed bench for ddrphy_pwr_rst_seq: expected output values are queued with their due cycle.
module tb_ddrphy_pwr_rst_seq;

    localparam int SVaa = 0, SVdd = 1, SVddq = 2, SPwrok = 3, SPresetn = 4, SDfi = 5;
    localparam int SPhyRst = 6, SRet = 7, SClkEn = 8, SBusy = 9, SDone = 10, SState = 11;

    localparam logic [3:0] QOff = 4'd0, QVaa = 4'd1, QVddq = 4'd3, QPwrok = 4'd4, QRun = 4'd6;
    localparam logic [3:0] QRet = 4'd10, QPdn = 4'd11;

    typedef struct {
        int         due;
        int         sig;
        logic [3:0] exp;
        string      tag;
    } exp_t;

    logic apb_clk = 1'b0;
    logic reset, pwr_up_req, warm_rst_req, ret_enter_req, ret_exit_req, pwr_dn_req;
    logic vaa_en, vdd_en, vddq_en, pwrok_out, presetn_out, dfi_reset_n_out, phy_reset_out;
    logic retention_out, clk_en, busy, done;
    logic [3:0] state_o;

    int   cyc = 0;
    int   t0 = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t keep[$];

    ddrphy_pwr_rst_seq dut (
        .apb_clk         (apb_clk),
        .reset           (reset),
        .pwr_up_req      (pwr_up_req),
        .warm_rst_req    (warm_rst_req),
        .ret_enter_req   (ret_enter_req),
        .ret_exit_req    (ret_exit_req),
        .pwr_dn_req      (pwr_dn_req),
        .vaa_en          (vaa_en),
        .vdd_en          (vdd_en),
        .vddq_en         (vddq_en),
        .pwrok_out       (pwrok_out),
        .presetn_out     (presetn_out),
        .dfi_reset_n_out (dfi_reset_n_out),
        .phy_reset_out   (phy_reset_out),
        .retention_out   (retention_out),
        .clk_en          (clk_en),
        .busy            (busy),
        .done            (done),
        .state_o         (state_o)
    );

    always #5 apb_clk = ~apb_clk;
    always @(posedge apb_clk) cyc <= cyc + 1;

    function automatic logic [3:0] obs(input int sig);
        case (sig)
            SVaa:     return {3'b0, vaa_en};
            SVdd:     return {3'b0, vdd_en};
            SVddq:    return {3'b0, vddq_en};
            SPwrok:   return {3'b0, pwrok_out};
            SPresetn: return {3'b0, presetn_out};
            SDfi:     return {3'b0, dfi_reset_n_out};
            SPhyRst:  return {3'b0, phy_reset_out};
            SRet:     return {3'b0, retention_out};
            SClkEn:   return {3'b0, clk_en};
            SBusy:    return {3'b0, busy};
            SDone:    return {3'b0, done};
            default:  return state_o;
        endcase
    endfunction

    // Compare every entry due this cycle; an entry already overdue counts as a failure.
    always @(negedge apb_clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due <= cyc) begin
                checks++;
                assert (sb[i].due == cyc && obs(sb[i].sig) === sb[i].exp) else begin
                    errors++;
                    $error("FAIL %s cyc=%0d due=%0d observed=%0h expected=%0h", sb[i].tag, cyc,
                           sb[i].due, obs(sb[i].sig), sb[i].exp);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic ex(input int d, input int sig, input logic [3:0] v, input string tag);
        sb.push_back('{due: t0 + d, sig: sig, exp: v, tag: tag});
    endtask

    task automatic at(input int d);
        while (cyc < t0 + d) @(negedge apb_clk);
    endtask

    initial begin
        reset = 1'b1;
        pwr_up_req = 1'b0;
        warm_rst_req = 1'b0;
        ret_enter_req = 1'b0;
        ret_exit_req = 1'b0;
        pwr_dn_req = 1'b0;
        repeat (3) @(negedge apb_clk);

        // Reset state
        t0 = cyc;
        ex(1, SState, QOff, "rst_state");
        ex(1, SPresetn, 4'd1, "rst_presetn");
        ex(1, SPhyRst, 4'd1, "rst_phy_reset");
        ex(1, SVaa, 4'd0, "rst_vaa");
        ex(1, SBusy, 4'd0, "rst_busy");
        ex(1, SDone, 4'd0, "rst_done");
        at(1);
        reset = 1'b0;
        ex(5, SState, QOff, "idle_off");
        at(6);

        // Cold power-up
        t0 = cyc;
        pwr_up_req = 1'b1;
        ex(1, SVaa, 4'd1, "cold_vaa");
        ex(1, SState, QVaa, "cold_state_vaa");
        ex(1, SBusy, 4'd1, "cold_busy");
        ex(8, SVdd, 4'd0, "cold_vdd_early");
        ex(9, SVdd, 4'd1, "cold_vdd");
        ex(16, SVddq, 4'd0, "cold_vddq_early");
        ex(17, SVddq, 4'd1, "cold_vddq");
        ex(17, SClkEn, 4'd1, "cold_clk_en");
        ex(17, SPresetn, 4'd0, "cold_presetn_low");
        ex(80, SPwrok, 4'd0, "cold_pwrok_early");
        ex(81, SPwrok, 4'd1, "cold_pwrok");
        ex(208, SPhyRst, 4'd1, "cold_phy_rst_held");
        ex(209, SPhyRst, 4'd0, "cold_phy_rst_rel");
        ex(209, SDfi, 4'd1, "cold_dfi_rel");
        ex(224, SPresetn, 4'd0, "cold_presetn_held");
        ex(224, SDone, 4'd0, "cold_done_early");
        ex(225, SPresetn, 4'd1, "cold_presetn_rel");
        ex(225, SDone, 4'd1, "cold_done");
        ex(225, SBusy, 4'd0, "cold_busy_low");
        ex(225, SState, QRun, "cold_state_run");
        ex(226, SDone, 4'd0, "cold_done_pulse");
        at(1);
        pwr_up_req = 1'b0;
        at(228);

        // Warm reset in RUN
        t0 = cyc;
        warm_rst_req = 1'b1;
        ex(1, SPresetn, 4'd0, "warm_presetn_low");
        ex(1, SBusy, 4'd1, "warm_busy");
        ex(16, SPhyRst, 4'd0, "warm_phy_early");
        ex(17, SPhyRst, 4'd1, "warm_phy_high");
        ex(100, SPwrok, 4'd1, "warm_pwrok_kept");
        ex(100, SDfi, 4'd1, "warm_dfi_kept");
        ex(144, SPhyRst, 4'd1, "warm_phy_held");
        ex(145, SPhyRst, 4'd0, "warm_phy_low");
        ex(160, SPresetn, 4'd0, "warm_presetn_held");
        ex(161, SPresetn, 4'd1, "warm_presetn_high");
        ex(161, SDone, 4'd1, "warm_done");
        ex(161, SPwrok, 4'd1, "warm_pwrok_end");
        at(1);
        warm_rst_req = 1'b0;
        at(164);

        // Retention entry
        t0 = cyc;
        ret_enter_req = 1'b1;
        ex(1, SRet, 4'd1, "rent_retention");
        ex(1, SClkEn, 4'd0, "rent_clk_off");
        ex(8, SVdd, 4'd1, "rent_vdd_held");
        ex(9, SVdd, 4'd0, "rent_vdd_off");
        ex(9, SVddq, 4'd0, "rent_vddq_off");
        ex(9, SPwrok, 4'd0, "rent_pwrok_off");
        ex(9, SVaa, 4'd1, "rent_vaa_kept");
        ex(9, SDfi, 4'd0, "rent_dfi_low");
        ex(9, SPhyRst, 4'd1, "rent_phy_reset");
        ex(9, SState, QRet, "rent_state_ret");
        ex(9, SDone, 4'd1, "rent_done");
        ex(9, SBusy, 4'd0, "rent_busy_low");
        at(1);
        ret_enter_req = 1'b0;
        at(14);

        // Retention exit
        t0 = cyc;
        ret_exit_req = 1'b1;
        ex(1, SVdd, 4'd1, "rexit_vdd");
        ex(1, SVaa, 4'd1, "rexit_vaa");
        ex(1, SRet, 4'd1, "rexit_ret_held");
        ex(216, SRet, 4'd1, "rexit_ret_late");
        ex(217, SRet, 4'd0, "rexit_ret_clear");
        ex(217, SState, QRun, "rexit_state_run");
        ex(217, SDone, 4'd1, "rexit_done");
        at(1);
        ret_exit_req = 1'b0;
        at(219);

        // Simultaneous requests in RUN: power-down wins
        t0 = cyc;
        warm_rst_req = 1'b1;
        ret_enter_req = 1'b1;
        pwr_dn_req = 1'b1;
        ex(1, SState, QPdn, "pdn_state");
        ex(1, SPhyRst, 4'd1, "pdn_phy_reset");
        ex(1, SDfi, 4'd0, "pdn_dfi_low");
        ex(1, SClkEn, 4'd1, "pdn_clk_en");
        ex(1, SRet, 4'd0, "pdn_no_retention");
        ex(128, SState, QPdn, "pdn_state_held");
        ex(129, SState, QOff, "pdn_state_off");
        ex(129, SDone, 4'd1, "pdn_done");
        ex(129, SVaa, 4'd0, "pdn_vaa_off");
        ex(129, SBusy, 4'd0, "pdn_busy_low");
        at(1);
        warm_rst_req = 1'b0;
        ret_enter_req = 1'b0;
        pwr_dn_req = 1'b0;
        at(132);

        // Warm request during cold-up VDDQ is ignored
        t0 = cyc;
        pwr_up_req = 1'b1;
        ex(17, SVddq, 4'd1, "ign_vddq");
        ex(40, SState, QVddq, "ign_state_vddq");
        ex(40, SPresetn, 4'd0, "ign_presetn");
        ex(81, SPwrok, 4'd1, "ign_pwrok");
        ex(209, SPhyRst, 4'd0, "ign_phy_rel");
        ex(224, SPresetn, 4'd0, "ign_presetn_held");
        ex(225, SPresetn, 4'd1, "ign_presetn_rel");
        ex(225, SDone, 4'd1, "ign_done");
        at(1);
        pwr_up_req = 1'b0;
        at(30);
        warm_rst_req = 1'b1;
        at(31);
        warm_rst_req = 1'b0;
        at(228);

        // Reset mid-PWROK: power down first, then cold up again
        t0 = cyc;
        pwr_dn_req = 1'b1;
        at(1);
        pwr_dn_req = 1'b0;
        ex(129, SState, QOff, "mid_pre_off");
        at(131);
        t0 = cyc;
        pwr_up_req = 1'b1;
        ex(100, SPwrok, 4'd1, "mid_pwrok_before");
        ex(100, SState, QPwrok, "mid_state_before");
        ex(101, SState, QOff, "mid_state_off");
        ex(101, SVaa, 4'd0, "mid_vaa");
        ex(101, SVdd, 4'd0, "mid_vdd");
        ex(101, SVddq, 4'd0, "mid_vddq");
        ex(101, SPwrok, 4'd0, "mid_pwrok");
        ex(101, SClkEn, 4'd0, "mid_clk_en");
        ex(101, SPresetn, 4'd1, "mid_presetn");
        ex(101, SPhyRst, 4'd1, "mid_phy_reset");
        ex(101, SDfi, 4'd0, "mid_dfi");
        ex(101, SRet, 4'd0, "mid_retention");
        ex(101, SBusy, 4'd0, "mid_busy");
        ex(101, SDone, 4'd0, "mid_done");
        ex(110, SState, QOff, "mid_stays_off");
        at(1);
        pwr_up_req = 1'b0;
        at(100);
        reset = 1'b1;
        at(101);
        reset = 1'b0;
        at(112);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
